// File: rtl/pe_chain_ctrl_if.sv
// rtl/pe_chain_ctrl_if.sv - weight, window and result handshakes of pe_chain_ctrl
interface pe_chain_ctrl_if #(
  parameter int NUM_PE = 4,
  parameter int WIDTH  = 14
);
  logic                 w_valid;
  logic                 w_ready;
  logic [26:0]          w_data;
  logic                 act_valid;
  logic                 act_ready;
  logic [NUM_PE*27-1:0] act_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_bit;
  logic [WIDTH-1:0]     out_psum;

  modport slave (
    input  w_valid, w_data, act_valid, act_data, out_ready,
    output w_ready, act_ready, out_valid, out_bit, out_psum
  );

  modport master (
    output w_valid, w_data, act_valid, act_data, out_ready,
    input  w_ready, act_ready, out_valid, out_bit, out_psum
  );
endinterface

// File: rtl/pe_chain_ctrl.sv
// rtl/pe_chain_ctrl.sv - job sequencer for a cascaded XNOR-popcount PE chain:
// weight load, per-slice skew, bias injection and credit-throttled result FIFO.
module pe_chain_ctrl #(
  parameter int NUM_PE    = 4,
  parameter int WIDTH     = 14,
  parameter int OUT_DEPTH = 4
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    start,
  input  logic [15:0]             num_win,
  input  logic signed [WIDTH-1:0] cfg_bias,
  pe_chain_ctrl_if.slave          bus,
  output logic                    pe_rst_n,
  output logic [NUM_PE*27-1:0]    pe_act,
  output logic [NUM_PE*27-1:0]    pe_weight,
  output logic [WIDTH-1:0]        pe_psum_in,
  input  logic [WIDTH-1:0]        pe_psum_out,
  output logic                    busy,
  output logic                    done
);
  localparam int AW    = NUM_PE * 27;
  localparam int WC_W  = $clog2(NUM_PE + 1);
  localparam int CNT_W = $clog2(OUT_DEPTH + 1);
  localparam int CW1   = CNT_W + 1;
  localparam int PTR_W = $clog2(OUT_DEPTH);

  localparam logic [WC_W-1:0]  LAST_SLICE = WC_W'(NUM_PE - 1);
  localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(OUT_DEPTH - 1);
  localparam logic [CW1-1:0]   CREDITS    = CW1'(OUT_DEPTH);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD_W = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;
  localparam logic [1:0] S_DRAIN  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [15:0]      num_win_q, num_win_d;
  logic [15:0]      issued_q, issued_d;
  logic [WIDTH-1:0] bias_q, bias_d;
  logic [WC_W-1:0]  wcnt_q, wcnt_d;
  logic [AW-1:0]    weight_q, weight_d;
  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic [CNT_W-1:0] fifo_count_q, fifo_count_d;
  logic [NUM_PE:0]  vpipe_q, vpipe_d;
  logic [WIDTH-1:0] fifo_q [OUT_DEPTH];
  logic [WIDTH-1:0] fifo_d [OUT_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

  logic             w_fire, act_fire, fifo_push, fifo_pop;
  logic             has_credit, drain_done, out_valid;
  logic [WIDTH-1:0] head;

  // A window is only admitted if its result already has a reserved FIFO slot.
  assign has_credit = ({1'b0, inflight_q} + {1'b0, fifo_count_q}) < CREDITS;
  assign w_fire     = bus.w_valid && bus.w_ready;
  assign act_fire   = bus.act_valid && bus.act_ready;
  assign fifo_push  = vpipe_q[NUM_PE];
  assign fifo_pop   = out_valid && bus.out_ready;
  assign out_valid  = fifo_count_q != '0;
  assign drain_done = (state_q == S_DRAIN) && (inflight_q == '0) && (fifo_count_q == '0);

  always_comb begin
    state_d   = state_q;
    num_win_d = num_win_q;
    bias_d    = bias_q;
    wcnt_d    = wcnt_q;
    weight_d  = weight_q;
    issued_d  = issued_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          num_win_d = num_win;
          bias_d    = cfg_bias;
          wcnt_d    = '0;
          issued_d  = '0;
          state_d   = S_LOAD_W;
        end
      end
      S_LOAD_W: begin
        if (w_fire) begin
          for (int k = 0; k < NUM_PE; k++) begin
            if (wcnt_q == WC_W'(k)) weight_d[k*27 +: 27] = bus.w_data;
          end
          if (wcnt_q == LAST_SLICE) begin
            wcnt_d  = '0;
            state_d = (num_win_q == '0) ? S_DRAIN : S_STREAM;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
      end
      S_STREAM: begin
        if (act_fire) begin
          issued_d = issued_q + 16'd1;
          if (issued_q + 16'd1 == num_win_q) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drain_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    inflight_d = inflight_q;
    case ({act_fire, fifo_push})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase
    vpipe_d = {vpipe_q[NUM_PE-1:0], act_fire};
  end

  always_comb begin
    fifo_d       = fifo_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fifo_count_d = fifo_count_q;
    if (fifo_push) begin
      for (int i = 0; i < OUT_DEPTH; i++) begin
        if (wr_ptr_q == PTR_W'(i)) fifo_d[i] = pe_psum_out;
      end
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    end
    if (fifo_pop) rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
    case ({fifo_push, fifo_pop})
      2'b10:   fifo_count_d = fifo_count_q + 1'b1;
      2'b01:   fifo_count_d = fifo_count_q - 1'b1;
      default: fifo_count_d = fifo_count_q;
    endcase
  end

  always_comb begin
    head = '0;
    for (int i = 0; i < OUT_DEPTH; i++) begin
      if (rd_ptr_q == PTR_W'(i)) head = fifo_q[i];
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q      <= S_IDLE;
      num_win_q    <= '0;
      issued_q     <= '0;
      bias_q       <= '0;
      wcnt_q       <= '0;
      weight_q     <= '0;
      inflight_q   <= '0;
      fifo_count_q <= '0;
      vpipe_q      <= '0;
      fifo_q       <= '{default: '0};
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      state_q      <= state_d;
      num_win_q    <= num_win_d;
      issued_q     <= issued_d;
      bias_q       <= bias_d;
      wcnt_q       <= wcnt_d;
      weight_q     <= weight_d;
      inflight_q   <= inflight_d;
      fifo_count_q <= fifo_count_d;
      vpipe_q      <= vpipe_d;
      fifo_q       <= fifo_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
    end
  end

  // Slice k rides a (k+1)-stage shift register so it reaches PE k together with its partial sum.
  for (genvar gk = 0; gk < NUM_PE; gk++) begin : g_skew
    logic [(gk+1)*27-1:0] skew_q, skew_d;
    logic [26:0]          slice_in;

    always_comb begin
      slice_in = act_fire ? bus.act_data[gk*27 +: 27] : 27'd0;
      skew_d   = '0;
      if (gk == 0) skew_d[26:0] = slice_in;
      else         skew_d = {skew_q[(gk+1)*27-28:0], slice_in};
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) skew_q <= '0;
      else         skew_q <= skew_d;
    end

    assign pe_act[gk*27 +: 27] = skew_q[gk*27 +: 27];
  end

  assign busy          = state_q != S_IDLE;
  assign pe_rst_n      = busy;
  assign done          = drain_done;
  assign pe_weight     = weight_q;
  assign pe_psum_in    = bias_q;
  assign bus.w_ready   = state_q == S_LOAD_W;
  assign bus.act_ready = (state_q == S_STREAM) && (issued_q < num_win_q) && has_credit;
  assign bus.out_valid = out_valid;
  assign bus.out_psum  = out_valid ? head : '0;
  assign bus.out_bit   = out_valid && !head[WIDTH-1];
endmodule

// File: tb/tb_pe_chain_ctrl.sv
// tb/tb_pe_chain_ctrl.sv - directed bench for pe_chain_ctrl with a behavioural PE chain
module tb_pe_chain_ctrl;
  localparam int NUM_PE    = 4;
  localparam int WIDTH     = 14;
  localparam int OUT_DEPTH = 4;
  localparam int AW        = NUM_PE * 27;

  logic                    clk_in = 1'b0;
  logic                    rst_in = 1'b0;
  logic                    start = 1'b0;
  logic [15:0]             num_win = '0;
  logic signed [WIDTH-1:0] cfg_bias = '0;
  logic                    pe_rst_n;
  logic [AW-1:0]           pe_act;
  logic [AW-1:0]           pe_weight;
  logic [WIDTH-1:0]        pe_psum_in;
  logic [WIDTH-1:0]        pe_psum_out;
  logic                    busy;
  logic                    done;

  int total = 0;
  int bad   = 0;

  pe_chain_ctrl_if #(.NUM_PE(NUM_PE), .WIDTH(WIDTH)) bus ();

  pe_chain_ctrl #(.NUM_PE(NUM_PE), .WIDTH(WIDTH), .OUT_DEPTH(OUT_DEPTH)) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .start       (start),
    .num_win     (num_win),
    .cfg_bias    (cfg_bias),
    .bus         (bus),
    .pe_rst_n    (pe_rst_n),
    .pe_act      (pe_act),
    .pe_weight   (pe_weight),
    .pe_psum_in  (pe_psum_in),
    .pe_psum_out (pe_psum_out),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk_in = ~clk_in;

  // Each PE adds +1 per matching bit and -1 per mismatching bit of its slice.
  logic signed [WIDTH-1:0] pm [NUM_PE] = '{default: '0};

  function automatic int contrib(input logic [26:0] a, input logic [26:0] w);
    logic [26:0] x;
    x = ~(a ^ w);
    return 2 * $countones(x) - 27;
  endfunction

  always @(posedge clk_in) begin
    if (!pe_rst_n) begin
      for (int k = 0; k < NUM_PE; k++) pm[k] <= '0;
    end else begin
      pm[0] <= WIDTH'(int'($signed(pe_psum_in)) + contrib(pe_act[26:0], pe_weight[26:0]));
      for (int k = 1; k < NUM_PE; k++)
        pm[k] <= WIDTH'(int'(pm[k-1]) + contrib(pe_act[k*27 +: 27], pe_weight[k*27 +: 27]));
    end
  end
  assign pe_psum_out = pm[NUM_PE-1];

  always @(negedge clk_in) begin
    if (rst_in && dut.fifo_push && !dut.fifo_pop && (int'(dut.fifo_count_q) == OUT_DEPTH)) begin
      bad++;
      $error("FAIL fifo_overflow: count=%0d required<%0d", dut.fifo_count_q, OUT_DEPTH);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d required %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic start_job(input int nw, input int bias);
    num_win  = 16'(nw);
    cfg_bias = WIDTH'(bias);
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic load_w(input logic [AW-1:0] w);
    int n;
    for (int k = 0; k < NUM_PE; k++) begin
      bus.w_valid = 1'b1;
      bus.w_data  = w[k*27 +: 27];
      n = 0;
      while (!bus.w_ready && n < 20) begin tick(); n++; end
      if (n >= 20) check("w_ready_timeout", bus.w_ready, 1);
      tick();
    end
    bus.w_valid = 1'b0;
  endtask

  task automatic send_act(input logic [AW-1:0] a);
    int n;
    bus.act_valid = 1'b1;
    bus.act_data  = a;
    n = 0;
    while (!bus.act_ready && n < 40) begin tick(); n++; end
    if (n >= 40) check("act_ready_timeout", bus.act_ready, 1);
    tick();
    bus.act_valid = 1'b0;
  endtask

  function automatic logic [26:0] pat(input int k);
    return 27'(32'h02D4F6B1 ^ (k * 32'h00137F11));
  endfunction

  function automatic logic [AW-1:0] win(input int i);
    logic [AW-1:0] r;
    r = '0;
    r[26:0] = 27'((64'd1 << i) - 64'd1);
    return r;
  endfunction

  task automatic run_one(input string tag, input int bias, input logic [AW-1:0] w,
                         input logic [AW-1:0] a, input int exp);
    int lat;
    bus.out_ready = 1'b1;
    start_job(1, bias);
    check({tag, "_busy"}, busy, 1);
    load_w(w);
    check({tag, "_weight"}, (pe_weight === w), 1);
    check({tag, "_psum_in"}, $signed(pe_psum_in), bias);
    send_act(a);
    check({tag, "_act0"}, pe_act[26:0], a[26:0]);
    tick();
    check({tag, "_act1"}, pe_act[53:27], a[53:27]);
    lat = 1;
    while (!bus.out_valid && lat < 40) begin tick(); lat++; end
    check({tag, "_latency"}, lat, NUM_PE + 1);
    check({tag, "_psum"}, $signed(bus.out_psum), exp);
    check({tag, "_bit"}, bus.out_bit, (exp >= 0) ? 1 : 0);
    tick();
    check({tag, "_done"}, done, 1);
    tick();
    check({tag, "_idle"}, {30'd0, busy, done}, 0);
  endtask

  initial begin
    logic [AW-1:0] w, a;
    int nacc, npop, n;
    logic acc, pp, seen;

    bus.w_valid = 1'b0;   bus.w_data = '0;
    bus.act_valid = 1'b0; bus.act_data = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_pe_rst_n", pe_rst_n, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_readies", {30'd0, bus.w_ready, bus.act_ready}, 0);
    check("rst_datapath", {29'd0, |pe_act, |pe_weight, |pe_psum_in}, 0);
    rst_in = 1'b1;
    tick();
    check("idle_w_ready", bus.w_ready, 0);

    run_one("basic", 0, '0, '0, 108);
    run_one("mismatch", 5, '0, {AW{1'b1}}, -103);

    for (int j = 0; j < NUM_PE; j++) begin
      for (int k = 0; k < NUM_PE; k++) begin
        w[k*27 +: 27] = pat(k);
        a[k*27 +: 27] = (k == j) ? pat(k) : ~pat(k);
      end
      run_one($sformatf("skew%0d", j), 0, w, a, -54);
    end

    bus.out_ready = 1'b0;
    start_job(10, 0);
    load_w('0);
    nacc = 0;
    bus.act_valid = 1'b1;
    bus.act_data  = win(0);
    for (int c = 0; c < 20; c++) begin
      acc = bus.act_ready;
      tick();
      if (acc) begin nacc++; bus.act_data = win(nacc); end
    end
    check("bp_accepts", nacc, OUT_DEPTH);
    check("bp_act_ready", bus.act_ready, 0);
    check("bp_head_psum", $signed(bus.out_psum), 108);
    bus.out_ready = 1'b1;
    npop = 0;
    n = 0;
    while (npop < 10 && n < 300) begin
      acc = bus.act_valid && bus.act_ready;
      pp  = bus.out_valid && bus.out_ready;
      if (pp) check($sformatf("bp_result%0d", npop), $signed(bus.out_psum), 108 - 2 * npop);
      tick();
      if (acc) begin
        nacc++;
        if (nacc == 10) bus.act_valid = 1'b0;
        else bus.act_data = win(nacc);
      end
      if (pp) npop++;
      n++;
    end
    check("bp_pops", npop, 10);
    check("bp_done", done, 1);
    tick();
    check("bp_idle", busy, 0);

    bus.out_ready = 1'b0;
    for (int k = 0; k < NUM_PE; k++) w[k*27 +: 27] = pat(k);
    start_job(10, 7);
    load_w(w);
    for (int i = 0; i < 3; i++) send_act(win(i));
    #2 rst_in = 1'b0;
    #1;
    check("mrst_busy", busy, 0);
    check("mrst_flags", {29'd0, pe_rst_n, bus.out_valid, done}, 0);
    check("mrst_datapath", {29'd0, |pe_act, |pe_weight, |pe_psum_in}, 0);
    check("mrst_readies", {30'd0, bus.w_ready, bus.act_ready}, 0);
    tick();
    rst_in = 1'b1;
    tick();
    run_one("post_rst", 0, '0, '0, 108);

    start_job(0, 0);
    load_w(w);
    check("nw0_done", done, 1);
    check("nw0_weight", (pe_weight === w), 1);
    check("nw0_out_valid", bus.out_valid, 0);
    tick();
    check("nw0_idle", {30'd0, busy, done}, 0);

    bus.out_ready = 1'b1;
    start_job(1, 0);
    num_win  = 16'd5;
    cfg_bias = WIDTH'(100);
    start    = 1'b1;
    tick();
    start    = 1'b0;
    load_w('0);
    check("sbusy_psum_in", $signed(pe_psum_in), 0);
    send_act('0);
    n = 0;
    while (!bus.out_valid && n < 40) begin tick(); n++; end
    check("sbusy_psum", $signed(bus.out_psum), 108);
    tick();
    check("sbusy_done", done, 1);
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      seen = seen | bus.out_valid | busy;
    end
    check("sbusy_no_extra", seen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
